// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-client RAM arbiter/controller.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2,
    INIT  = 2'd3
  } arb_state_t;

  localparam int CLI0 = 0;
  localparam int CLI1 = 1;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with a one-bit preference pointer (0 favours client 0).
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_hold,
  input  logic       i_upd_en,
  input  logic       i_upd_ptr,
  output logic [1:0] o_gnt
);

  logic r_ptr;

  always_comb begin
    o_gnt = 2'b00;
    if (i_req[CLI0] && i_req[CLI1]) begin
      o_gnt[CLI0] = ~r_ptr;
      o_gnt[CLI1] = r_ptr;
    end else begin
      o_gnt = i_req;
    end
  end

  // A contested grant hands preference to the loser; a lock release forces it explicitly.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= 1'b0;
    end else if (i_upd_en) begin
      r_ptr <= i_upd_ptr;
    end else if (!i_hold && i_req[CLI0] && i_req[CLI1]) begin
      r_ptr <= ~r_ptr;
    end else begin
      r_ptr <= r_ptr;
    end
  end

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// Two-client round-robin controller for a single-port RAM with lock and 2-cycle read return.
// Optional power-up clear sweep enabled by defining MEM_ARB_INIT_CLEAR_EN.
module mem_arbiter_ctrl
  import mem_arb_pkg::*;
#(
  parameter int                ADDR_W     = ADDR_W_DEF,
  parameter int                DATA_W     = DATA_W_DEF,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              mem_clk,
  input  logic              mem_rst,
  input  logic              c0_req,
  input  logic              c0_we,
  input  logic              c0_lock,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [DATA_W-1:0] c0_wdata,
  input  logic              c1_req,
  input  logic              c1_we,
  input  logic              c1_lock,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic              c0_gnt,
  output logic              c1_gnt,
  output logic              c0_rvalid,
  output logic              c1_rvalid,
  output logic [DATA_W-1:0] c0_rdata,
  output logic [DATA_W-1:0] c1_rdata,
  output logic [ADDR_W-1:0] mc_address_mem,
  output logic [DATA_W-1:0] mc_data_mem,
  output logic              mc_we_mem,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              mc_busy
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_any_gnt;
  logic              w_hold;
  logic              w_release;
  logic              w_rel_ptr;
  logic              w_cmd_we;
  logic [ADDR_W-1:0] w_cmd_addr;
  logic [DATA_W-1:0] w_cmd_wdata;
  logic [ADDR_W-1:0] r_addr_hold;
  logic [DATA_W-1:0] r_data_hold;
  logic              r_p1_valid;
  logic              r_p1_tag;
  logic              w_init_wr;
  logic              w_init_last;
  logic [ADDR_W-1:0] w_init_addr;

`ifdef MEM_ARB_INIT_CLEAR_EN
  localparam arb_state_t RST_STATE = INIT;
  logic [ADDR_W-1:0] r_init_cnt;

  assign w_init_wr   = (r_state == INIT) & ~mem_rst;
  assign w_init_addr = r_init_cnt;
  assign w_init_last = (r_init_cnt == {ADDR_W{1'b1}});

  // Sweep address counter; restarts from zero on every reset.
  always_ff @(posedge mem_clk or posedge mem_rst) begin
    if (mem_rst) begin
      r_init_cnt <= '0;
    end else if (r_state == INIT) begin
      r_init_cnt <= r_init_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      r_init_cnt <= r_init_cnt;
    end
  end
`else
  localparam arb_state_t RST_STATE = IDLE;
  assign w_init_wr   = 1'b0;
  assign w_init_addr = '0;
  assign w_init_last = 1'b1;
`endif

  // Requests seen by the arbiter: only the lock owner while locked, nobody in reset or INIT.
  always_comb begin
    w_req = 2'b00;
    if (mem_rst) begin
      w_req = 2'b00;
    end else begin
      case (r_state)
        IDLE:    w_req = {c1_req, c0_req};
        LOCK0:   w_req = {1'b0, c0_req};
        LOCK1:   w_req = {c1_req, 1'b0};
        default: w_req = 2'b00;
      endcase
    end
  end

  assign w_hold    = (r_state != IDLE);
  assign w_release = ((r_state == LOCK0) || (r_state == LOCK1)) && (w_state_nxt == IDLE);
  assign w_rel_ptr = (r_state == LOCK0);

  rr_arb2 u_rr_arb2 (
    .i_clk     (mem_clk),
    .i_rst     (mem_rst),
    .i_req     (w_req),
    .i_hold    (w_hold),
    .i_upd_en  (w_release),
    .i_upd_ptr (w_rel_ptr),
    .o_gnt     (w_gnt)
  );

  assign w_any_gnt   = |w_gnt;
  assign c0_gnt      = w_gnt[CLI0];
  assign c1_gnt      = w_gnt[CLI1];
  assign w_cmd_we    = w_gnt[CLI1] ? c1_we    : c0_we;
  assign w_cmd_addr  = w_gnt[CLI1] ? c1_addr  : c0_addr;
  assign w_cmd_wdata = w_gnt[CLI1] ? c1_wdata : c0_wdata;
  assign mc_busy     = (r_state != IDLE);

  // Lock FSM next-state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_gnt[CLI0] && c0_lock) begin
          w_state_nxt = LOCK0;
        end else if (w_gnt[CLI1] && c1_lock) begin
          w_state_nxt = LOCK1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      LOCK0:   w_state_nxt = (c0_req && c0_lock) ? LOCK0 : IDLE;
      LOCK1:   w_state_nxt = (c1_req && c1_lock) ? LOCK1 : IDLE;
      INIT:    w_state_nxt = w_init_last ? IDLE : INIT;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge mem_clk or posedge mem_rst) begin
    if (mem_rst) begin
      r_state <= RST_STATE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // RAM port drive: idle cycles replay the last address with write disabled.
  always_comb begin
    mc_we_mem      = 1'b0;
    mc_address_mem = r_addr_hold;
    mc_data_mem    = r_data_hold;
    if (w_init_wr) begin
      mc_we_mem      = 1'b1;
      mc_address_mem = w_init_addr;
      mc_data_mem    = INIT_VALUE;
    end else if (w_any_gnt) begin
      mc_we_mem      = w_cmd_we;
      mc_address_mem = w_cmd_addr;
      mc_data_mem    = w_cmd_wdata;
    end else begin
      mc_we_mem      = 1'b0;
    end
  end

  // Last issued address/data, held on idle cycles.
  always_ff @(posedge mem_clk or posedge mem_rst) begin
    if (mem_rst) begin
      r_addr_hold <= '0;
      r_data_hold <= INIT_VALUE;
    end else if (w_init_wr || w_any_gnt) begin
      r_addr_hold <= mc_address_mem;
      r_data_hold <= mc_data_mem;
    end else begin
      r_addr_hold <= r_addr_hold;
      r_data_hold <= r_data_hold;
    end
  end

  // Read return: stage 1 tracks the RAM access, stage 2 captures RAM data per client.
  always_ff @(posedge mem_clk or posedge mem_rst) begin
    if (mem_rst) begin
      r_p1_valid <= 1'b0;
      r_p1_tag   <= 1'b0;
      c0_rvalid  <= 1'b0;
      c1_rvalid  <= 1'b0;
      c0_rdata   <= '0;
      c1_rdata   <= '0;
    end else begin
      r_p1_valid <= w_any_gnt & ~w_cmd_we;
      r_p1_tag   <= w_gnt[CLI1];
      c0_rvalid  <= r_p1_valid & ~r_p1_tag;
      c1_rvalid  <= r_p1_valid & r_p1_tag;
      c0_rdata   <= (r_p1_valid && !r_p1_tag) ? mem_data_out : c0_rdata;
      c1_rdata   <= (r_p1_valid && r_p1_tag)  ? mem_data_out : c1_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Self-checking bench for mem_arbiter_ctrl with a behavioural RAM and arbitration model.
// Honours MEM_ARB_INIT_CLEAR_EN to match the DUT build.
module tb_mem_arbiter_ctrl;

  localparam int NRAND = 400;
  localparam logic [31:0] INIT_VAL = 32'h0000_0000;

  logic        mem_clk = 1'b0;
  logic        mem_rst = 1'b1;
  logic        c0_req = 1'b0, c0_we = 1'b0, c0_lock = 1'b0;
  logic [5:0]  c0_addr = 6'd0;
  logic [31:0] c0_wdata = 32'd0;
  logic        c1_req = 1'b0, c1_we = 1'b0, c1_lock = 1'b0;
  logic [5:0]  c1_addr = 6'd0;
  logic [31:0] c1_wdata = 32'd0;
  logic        c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, mc_we_mem, mc_busy;
  logic [31:0] c0_rdata, c1_rdata, mc_data_mem, mem_data_out;
  logic [5:0]  mc_address_mem;

  int errors = 0;
  int checks = 0;

  logic [31:0] ram [64];
  logic [5:0]  ram_raddr;
  logic [31:0] model_mem [64];
  bit          ev [2][0:NRAND+1];
  logic [31:0] ed [2][0:NRAND+1];

  always #5 mem_clk = ~mem_clk;

  // Single-port RAM: registered read address, write-first.
  always @(posedge mem_clk) begin
    if (mc_we_mem) ram[mc_address_mem] <= mc_data_mem;
    ram_raddr <= mc_address_mem;
  end
  assign mem_data_out = ram[ram_raddr];

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'hC0DE_0000 | i;
  end

  mem_arbiter_ctrl dut (
    .mem_clk(mem_clk), .mem_rst(mem_rst),
    .c0_req(c0_req), .c0_we(c0_we), .c0_lock(c0_lock), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c1_req(c1_req), .c1_we(c1_we), .c1_lock(c1_lock), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c0_gnt(c0_gnt), .c1_gnt(c1_gnt), .c0_rvalid(c0_rvalid), .c1_rvalid(c1_rvalid),
    .c0_rdata(c0_rdata), .c1_rdata(c1_rdata),
    .mc_address_mem(mc_address_mem), .mc_data_mem(mc_data_mem), .mc_we_mem(mc_we_mem),
    .mem_data_out(mem_data_out), .mc_busy(mc_busy)
  );

  task automatic set_c(input int c, input logic req, input logic we, input logic lock,
                       input logic [5:0] a, input logic [31:0] d);
    if (c == 0) begin
      c0_req = req; c0_we = we; c0_lock = lock; c0_addr = a; c0_wdata = d;
    end else begin
      c1_req = req; c1_we = we; c1_lock = lock; c1_addr = a; c1_wdata = d;
    end
  endtask

  task automatic idle_all();
    set_c(0, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
    set_c(1, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
  endtask

  task automatic apply_reset();
    idle_all();
    mem_rst = 1'b1;
    repeat (2) @(negedge mem_clk);
    mem_rst = 1'b0;
`ifdef MEM_ARB_INIT_CLEAR_EN
    repeat (64) @(negedge mem_clk);
`endif
  endtask

  task automatic test_reset();
    set_c(0, 1'b1, 1'b1, 1'b1, 6'd3, 32'h1);
    set_c(1, 1'b1, 1'b1, 1'b1, 6'd4, 32'h2);
    @(negedge mem_clk);
    checks++; if (c0_gnt !== 1'b0 || c1_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b%b expected 00", c1_gnt, c0_gnt); end
    checks++; if (mc_we_mem !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", mc_we_mem); end
    checks++; if (c0_rvalid !== 1'b0 || c1_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b%b expected 00", c1_rvalid, c0_rvalid); end
    checks++; if (c0_rdata !== 32'd0 || c1_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h %h expected 0", c0_rdata, c1_rdata); end
    checks++; if (mc_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", mc_busy); end
    apply_reset();
  endtask

  task automatic test_write_read();
    apply_reset();
    set_c(0, 1'b1, 1'b1, 1'b0, 6'd5, 32'hDEADBEEF);
    #1;
    checks++; if (c0_gnt !== 1'b1 || mc_we_mem !== 1'b1 || mc_address_mem !== 6'd5 || mc_data_mem !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_issue: got gnt=%b we=%b a=%0d d=%h expected 1 1 5 deadbeef", c0_gnt, mc_we_mem, mc_address_mem, mc_data_mem); end
    @(negedge mem_clk);
    set_c(0, 1'b1, 1'b0, 1'b0, 6'd5, 32'd0);
    #1;
    checks++; if (c0_gnt !== 1'b1 || mc_we_mem !== 1'b0) begin errors++; $display("FAIL rd_issue: got gnt=%b we=%b expected 1 0", c0_gnt, mc_we_mem); end
    @(negedge mem_clk);
    idle_all();
    checks++; if (c0_rvalid !== 1'b0 || c1_rvalid !== 1'b0) begin errors++; $display("FAIL rd_early: got %b%b expected 00", c1_rvalid, c0_rvalid); end
    @(negedge mem_clk);
    checks++; if (c0_rvalid !== 1'b1 || c0_rdata !== 32'hDEADBEEF || c1_rvalid !== 1'b0) begin
      errors++; $display("FAIL rd_return: got v0=%b d=%h v1=%b expected 1 deadbeef 0", c0_rvalid, c0_rdata, c1_rvalid); end
    @(negedge mem_clk);
    checks++; if (c0_rvalid !== 1'b0) begin errors++; $display("FAIL rd_pulse: got %b expected 0", c0_rvalid); end
  endtask

  task automatic test_alternate();
    bit e0;
    apply_reset();
    set_c(0, 1'b1, 1'b1, 1'b0, 6'd10, 32'hAAAA0010);
    @(negedge mem_clk);
    set_c(0, 1'b1, 1'b1, 1'b0, 6'd20, 32'hBBBB0020);
    @(negedge mem_clk);
    for (int k = 0; k < 8; k++) begin
      if (k >= 2) begin
        e0 = ((k - 2) % 2 == 0);
        checks++; if (c0_rvalid !== e0 || c1_rvalid !== !e0) begin errors++; $display("FAIL alt_rvalid%0d: got %b%b expected %b%b", k, c1_rvalid, c0_rvalid, !e0, e0); end
        checks++; if ((e0 && c0_rdata !== 32'hAAAA0010) || (!e0 && c1_rdata !== 32'hBBBB0020)) begin
          errors++; $display("FAIL alt_rdata%0d: got %h %h", k, c0_rdata, c1_rdata); end
      end else begin
        checks++; if (c0_rvalid !== 1'b0 || c1_rvalid !== 1'b0) begin errors++; $display("FAIL alt_rvalid%0d: got %b%b expected 00", k, c1_rvalid, c0_rvalid); end
      end
      if (k < 6) begin
        set_c(0, 1'b1, 1'b0, 1'b0, 6'd10, 32'd0);
        set_c(1, 1'b1, 1'b0, 1'b0, 6'd20, 32'd0);
        #1;
        checks++; if (c0_gnt !== (k % 2 == 0) || c1_gnt !== (k % 2 == 1)) begin
          errors++; $display("FAIL alt_gnt%0d: got %b%b expected %b%b", k, c1_gnt, c0_gnt, (k % 2 == 1), (k % 2 == 0)); end
      end else begin
        idle_all();
      end
      @(negedge mem_clk);
    end
  endtask

  task automatic test_lock();
    apply_reset();
    set_c(0, 1'b1, 1'b1, 1'b0, 6'd9, 32'h99);
    @(negedge mem_clk);
    set_c(0, 1'b1, 1'b0, 1'b0, 6'd1, 32'd0);
    set_c(1, 1'b1, 1'b0, 1'b1, 6'd9, 32'd0);
    #1;
    checks++; if (c0_gnt !== 1'b1 || c1_gnt !== 1'b0) begin errors++; $display("FAIL lock_pre: got %b%b expected 01", c1_gnt, c0_gnt); end
    @(negedge mem_clk);
    #1;
    checks++; if (c0_gnt !== 1'b0 || c1_gnt !== 1'b1 || mc_busy !== 1'b0) begin
      errors++; $display("FAIL lock_take: got g=%b%b busy=%b expected 10 0", c1_gnt, c0_gnt, mc_busy); end
    @(negedge mem_clk);
    set_c(1, 1'b1, 1'b1, 1'b0, 6'd9, 32'h1);
    #1;
    checks++; if (c0_gnt !== 1'b0 || c1_gnt !== 1'b1 || mc_busy !== 1'b1 || mc_we_mem !== 1'b1 || mc_address_mem !== 6'd9) begin
      errors++; $display("FAIL lock_hold: got g=%b%b busy=%b we=%b a=%0d expected 10 1 1 9", c1_gnt, c0_gnt, mc_busy, mc_we_mem, mc_address_mem); end
    checks++; if (c0_rvalid !== 1'b1) begin errors++; $display("FAIL lock_c0_rvalid: got %b expected 1", c0_rvalid); end
    @(negedge mem_clk);
    set_c(1, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
    #1;
    checks++; if (c0_gnt !== 1'b1 || mc_busy !== 1'b0) begin errors++; $display("FAIL lock_release: got g0=%b busy=%b expected 1 0", c0_gnt, mc_busy); end
    checks++; if (c1_rvalid !== 1'b1 || c1_rdata !== 32'h99) begin errors++; $display("FAIL lock_rdata: got v=%b d=%h expected 1 99", c1_rvalid, c1_rdata); end
    @(negedge mem_clk);
    idle_all();
    repeat (2) @(negedge mem_clk);
  endtask

  task automatic test_write_first();
    set_c(0, 1'b1, 1'b1, 1'b0, 6'd63, 32'hA5A5A5A5);
    #1;
    checks++; if (c0_gnt !== 1'b1 || mc_we_mem !== 1'b1) begin errors++; $display("FAIL wf_write: got gnt=%b we=%b expected 1 1", c0_gnt, mc_we_mem); end
    @(negedge mem_clk);
    set_c(0, 1'b1, 1'b0, 1'b0, 6'd63, 32'd0);
    @(negedge mem_clk);
    idle_all();
    @(negedge mem_clk);
    checks++; if (c0_rvalid !== 1'b1 || c0_rdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL wf_rdata: got v=%b d=%h expected 1 a5a5a5a5", c0_rvalid, c0_rdata); end
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (mc_we_mem !== 1'b0 || mc_address_mem !== 6'd63) begin
        errors++; $display("FAIL wf_idle%0d: got we=%b a=%0d expected 0 63", k, mc_we_mem, mc_address_mem); end
      @(negedge mem_clk);
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] exp_d;
    apply_reset();
    set_c(0, 1'b1, 1'b1, 1'b0, 6'd5, 32'h12345678);
    @(negedge mem_clk);
    set_c(0, 1'b1, 1'b0, 1'b1, 6'd5, 32'd0);
    #1;
    checks++; if (c0_gnt !== 1'b1) begin errors++; $display("FAIL rm_gnt: got %b expected 1", c0_gnt); end
    @(negedge mem_clk);
    checks++; if (mc_busy !== 1'b1) begin errors++; $display("FAIL rm_locked: got %b expected 1", mc_busy); end
    idle_all();
    mem_rst = 1'b1;
    #1;
    checks++; if (mc_busy !== 1'b0) begin errors++; $display("FAIL rm_busy_clr: got %b expected 0", mc_busy); end
    repeat (2) @(negedge mem_clk);
    mem_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge mem_clk);
      checks++; if (c0_rvalid !== 1'b0 || c1_rvalid !== 1'b0) begin errors++; $display("FAIL rm_drop%0d: got %b%b expected 00", k, c1_rvalid, c0_rvalid); end
    end
`ifdef MEM_ARB_INIT_CLEAR_EN
    repeat (64) @(negedge mem_clk);
    exp_d = INIT_VAL;
`else
    exp_d = 32'h12345678;
`endif
    set_c(1, 1'b1, 1'b0, 1'b0, 6'd5, 32'd0);
    #1;
    checks++; if (c1_gnt !== 1'b1 || mc_busy !== 1'b0) begin errors++; $display("FAIL rm_unlock: got g1=%b busy=%b expected 1 0", c1_gnt, mc_busy); end
    @(negedge mem_clk);
    idle_all();
    @(negedge mem_clk);
    checks++; if (c1_rvalid !== 1'b1 || c1_rdata !== exp_d) begin errors++; $display("FAIL rm_data: got v=%b d=%h expected 1 %h", c1_rvalid, c1_rdata, exp_d); end
  endtask

`ifdef MEM_ARB_INIT_CLEAR_EN
  task automatic test_init();
    int first;
    logic [5:0] rd_addr [3];
    rd_addr[0] = 6'd0; rd_addr[1] = 6'd31; rd_addr[2] = 6'd63;
    for (int k = 0; k < 3; k++) begin
      set_c(0, 1'b1, 1'b1, 1'b0, rd_addr[k], 32'h5A5A_0000 | k);
      @(negedge mem_clk);
    end
    idle_all();
    mem_rst = 1'b1;
    @(negedge mem_clk);
    mem_rst = 1'b0;
    repeat (20) @(negedge mem_clk);
    mem_rst = 1'b1;
    set_c(0, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0);
    @(negedge mem_clk);
    mem_rst = 1'b0;
    #1;
    first = -1;
    for (int n = 0; n < 200; n++) begin
      if (c0_gnt === 1'b1) begin
        first = n;
        break;
      end
      if (n == 10) begin
        checks++; if (mc_busy !== 1'b1) begin errors++; $display("FAIL init_busy: got %b expected 1", mc_busy); end
      end
      @(negedge mem_clk);
      #1;
    end
    checks++; if (first != 64) begin errors++; $display("FAIL init_first_gnt: got %0d expected 64", first); end
    for (int k = 0; k < 5; k++) begin
      @(negedge mem_clk);
      if (k >= 1 && k <= 3) begin
        checks++; if (c0_rvalid !== 1'b1 || c0_rdata !== INIT_VAL) begin
          errors++; $display("FAIL init_data%0d: got v=%b d=%h expected 1 %h", k, c0_rvalid, c0_rdata, INIT_VAL); end
      end
      if (k < 2) set_c(0, 1'b1, 1'b0, 1'b0, rd_addr[k + 1], 32'd0);
      else idle_all();
    end
  endtask
`endif

  task automatic test_random();
    int owner, pref, g, last_addr;
    logic rq [2];
    logic we [2];
    logic lk [2];
    logic [5:0]  ad [2];
    logic [31:0] wd [2];
    bit pend [2];
    apply_reset();
    for (int a = 0; a < 64; a++) begin
      model_mem[a] = $urandom;
      set_c(0, 1'b1, 1'b1, 1'b0, 6'(a), model_mem[a]);
      #1;
      checks++; if (c0_gnt !== 1'b1 || mc_we_mem !== 1'b1 || mc_address_mem !== 6'(a)) begin
        errors++; $display("FAIL preload%0d: got gnt=%b we=%b a=%0d", a, c0_gnt, mc_we_mem, mc_address_mem); end
      @(negedge mem_clk);
    end
    idle_all();
    owner = -1; pref = 0; last_addr = 63;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < NRAND + 2; i++) begin
        ev[c][i] = 1'b0; ed[c][i] = 32'd0;
      end
    end
    for (int cyc = 0; cyc < NRAND + 2; cyc++) begin
      checks++; if (c0_rvalid !== ev[0][cyc] || c1_rvalid !== ev[1][cyc]) begin
        errors++; $display("FAIL rnd_rvalid@%0d: got %b%b expected %b%b", cyc, c1_rvalid, c0_rvalid, ev[1][cyc], ev[0][cyc]); end
      if (ev[0][cyc]) begin
        checks++; if (c0_rdata !== ed[0][cyc]) begin errors++; $display("FAIL rnd_rdata0@%0d: got %h expected %h", cyc, c0_rdata, ed[0][cyc]); end
      end
      if (ev[1][cyc]) begin
        checks++; if (c1_rdata !== ed[1][cyc]) begin errors++; $display("FAIL rnd_rdata1@%0d: got %h expected %h", cyc, c1_rdata, ed[1][cyc]); end
      end
      if (cyc < NRAND) begin
        for (int c = 0; c < 2; c++) begin
          if (!pend[c]) begin
            rq[c] = ($urandom_range(0, 3) != 0);
            we[c] = 1'($urandom_range(0, 1));
            lk[c] = ($urandom_range(0, 5) == 0);
            ad[c] = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 63));
            wd[c] = $urandom;
          end
          set_c(c, rq[c], we[c], lk[c], ad[c], wd[c]);
        end
        if (owner >= 0) g = rq[owner] ? owner : -1;
        else if (rq[0] && rq[1]) begin g = pref; pref = 1 - g; end
        else if (rq[0]) g = 0;
        else if (rq[1]) g = 1;
        else g = -1;
        if (owner >= 0) begin
          if (!(g == owner && lk[owner])) begin pref = 1 - owner; owner = -1; end
        end else if (g >= 0 && lk[g]) begin
          owner = g;
        end
        #1;
        checks++; if (c0_gnt !== (g == 0) || c1_gnt !== (g == 1)) begin
          errors++; $display("FAIL rnd_gnt@%0d: got %b%b expected client %0d", cyc, c1_gnt, c0_gnt, g); end
        if (g >= 0) begin
          checks++; if (mc_we_mem !== we[g] || mc_address_mem !== ad[g] || (we[g] && mc_data_mem !== wd[g])) begin
            errors++; $display("FAIL rnd_port@%0d: got we=%b a=%0d d=%h expected %b %0d %h", cyc, mc_we_mem, mc_address_mem, mc_data_mem, we[g], ad[g], wd[g]); end
          last_addr = ad[g];
          if (we[g]) model_mem[ad[g]] = wd[g];
          else begin ev[g][cyc + 2] = 1'b1; ed[g][cyc + 2] = model_mem[ad[g]]; end
        end else begin
          checks++; if (mc_we_mem !== 1'b0 || mc_address_mem !== 6'(last_addr)) begin
            errors++; $display("FAIL rnd_idle@%0d: got we=%b a=%0d expected 0 %0d", cyc, mc_we_mem, mc_address_mem, last_addr); end
        end
        for (int c = 0; c < 2; c++) pend[c] = rq[c] && (g != c);
      end else begin
        idle_all();
      end
      @(negedge mem_clk);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_alternate();
    test_lock();
    test_write_first();
    test_reset_midop();
`ifdef MEM_ARB_INIT_CLEAR_EN
    test_init();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
